// File: rtl/spi_cfg_sync.sv
// AXI-to-SPI configuration synchronizer: per-field multi-flop sync plus stability
// counter, and a snapshot FSM that freezes the config while the SPI subsystem runs.

module spi_cfg_sync_field #(
    parameter int W            = 1,
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] sync,
    output logic         stable
);
    localparam int CW = $clog2(STABLE_COUNT + 1);

    logic [DEPTH-1:0][W-1:0] chain;
    logic [W-1:0]            prev;
    logic [CW-1:0]           cnt;

    assign sync = chain[DEPTH-1];
    // A fresh change is visible as sync != prev one cycle before the counter
    // clears, so gate on it to keep a stale saturated count from vouching for it.
    assign stable = (cnt == CW'(STABLE_COUNT)) && (sync == prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= '0;
            cnt   <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
            prev  <= sync;
            if (sync == prev) begin
                if (cnt != CW'(STABLE_COUNT)) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module spi_cfg_sync #(
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_en,
    input  logic        integ_en,
    input  logic [14:0] integ_thresh_avg,
    input  logic [31:0] integ_window,
    input  logic [7:0]  dac_n_cs_high_time,
    input  logic [7:0]  adc_n_cs_high_time,
    output logic        spi_en_stable,
    output logic        integ_en_stable,
    output logic [14:0] integ_thresh_avg_stable,
    output logic [31:0] integ_window_stable,
    output logic [7:0]  dac_n_cs_high_time_stable,
    output logic [7:0]  adc_n_cs_high_time_stable,
    output logic        cfg_change_err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic        en_s, ie_s;
    logic [14:0] th_s;
    logic [31:0] win_s;
    logic [7:0]  dac_s, adc_s;
    logic        en_st, ie_st, th_st, win_st, dac_st, adc_st;

    spi_cfg_sync_field #(.W(1),  .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_en (
        .clk(clk), .rst(rst), .d(spi_en), .sync(en_s), .stable(en_st));
    spi_cfg_sync_field #(.W(1),  .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_ie (
        .clk(clk), .rst(rst), .d(integ_en), .sync(ie_s), .stable(ie_st));
    spi_cfg_sync_field #(.W(15), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_th (
        .clk(clk), .rst(rst), .d(integ_thresh_avg), .sync(th_s), .stable(th_st));
    spi_cfg_sync_field #(.W(32), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_win (
        .clk(clk), .rst(rst), .d(integ_window), .sync(win_s), .stable(win_st));
    spi_cfg_sync_field #(.W(8),  .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_dac (
        .clk(clk), .rst(rst), .d(dac_n_cs_high_time), .sync(dac_s), .stable(dac_st));
    spi_cfg_sync_field #(.W(8),  .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_adc (
        .clk(clk), .rst(rst), .d(adc_n_cs_high_time), .sync(adc_s), .stable(adc_st));

    logic all_stable, cfg_moved;
    assign all_stable = ie_st && th_st && win_st && dac_st && adc_st;
    assign cfg_moved  = (ie_st  && (ie_s  != integ_en_stable))
                     || (th_st  && (th_s  != integ_thresh_avg_stable))
                     || (win_st && (win_s != integ_window_stable))
                     || (dac_st && (dac_s != dac_n_cs_high_time_stable))
                     || (adc_st && (adc_s != adc_n_cs_high_time_stable));

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            spi_en_stable             <= 1'b0;
            integ_en_stable           <= 1'b0;
            integ_thresh_avg_stable   <= '0;
            integ_window_stable       <= '0;
            dac_n_cs_high_time_stable <= '0;
            adc_n_cs_high_time_stable <= '0;
            cfg_change_err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spi_en_stable <= 1'b0;
                    if (en_s && en_st && all_stable) begin
                        integ_en_stable           <= ie_s;
                        integ_thresh_avg_stable   <= th_s;
                        integ_window_stable       <= win_s;
                        dac_n_cs_high_time_stable <= dac_s;
                        adc_n_cs_high_time_stable <= adc_s;
                        spi_en_stable             <= 1'b1;
                        cfg_change_err            <= 1'b0;
                        state                     <= RUN;
                    end
                end
                RUN: begin
                    if (cfg_moved) cfg_change_err <= 1'b1;
                    if (!en_s && en_st) begin
                        spi_en_stable <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
